// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU result path: TX FSM states, flag bit positions, payload width.
// Pure declarations; no latency, no flow control.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam int TX_PAYLOAD_BITS = 12;

  function automatic logic even_parity(input logic [TX_PAYLOAD_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/cpu_baud_tick.sv
// Bit-time generator: tick_o pulses on the last cycle of every CLKS_PER_BIT-cycle bit.
// Restarts from zero the cycle after en_i drops; no backpressure.
module cpu_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_result_tx.sv
// Serialises a captured {flags,result} word as a UART-style frame; start bit appears 1 cycle after capture.
// Captures arriving mid-frame are dropped and flagged on the sticky overrun_o.
module cpu_result_tx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic [3:0] flags_i,
  input  logic       capture_i,
  input  logic       clr_overrun_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overrun_o
);

  localparam logic [3:0] LAST_IDX = 4'(TX_PAYLOAD_BITS - 1);

  tx_state_t                   state_q, state_d;
  logic [TX_PAYLOAD_BITS-1:0]  shift_q, shift_d;
  logic [3:0]                  idx_q, idx_d;
  logic                        par_q, par_d;
  logic                        tx_q, tx_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        ovr_q, ovr_d;
  logic                        baud_en;
  logic                        tick;

  assign baud_en = (state_q != IDLE);

  cpu_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (baud_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    // A dropped capture outranks a clear in the same cycle.
    if (capture_i && state_q != IDLE) begin
      ovr_d = 1'b1;
    end else if (clr_overrun_i) begin
      ovr_d = 1'b0;
    end

    // tx_d always reflects the bit of the state being entered, keeping tx_o registered.
    unique case (state_q)
      IDLE: begin
        if (capture_i) begin
          shift_d = {flags_i, data_i};
          par_d   = even_parity({flags_i, data_i});
          idx_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = {1'b0, shift_q[TX_PAYLOAD_BITS-1:1]};
            idx_d   = idx_q + 4'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_cpu_result_tx.sv
// Bench for cpu_result_tx: slow parity instance (A) and fast no-parity instance (B),
// per-cycle {tx,busy,done} expectations queued at capture and popped each cycle.
`timescale 1ns/1ps
module tb_cpu_result_tx;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] flags = '0;
  logic       cap_a = 1'b0;
  logic       cap_b = 1'b0;
  logic       clr = 1'b0;
  logic       tx_a, busy_a, done_a, ovr_a;
  logic       tx_b, busy_b, done_b, ovr_b;

  int errors = 0;
  int checks = 0;

  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic [2:0] ea, eb;

  always #5 clk = ~clk;

  cpu_result_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .flags_i(flags), .capture_i(cap_a),
    .clr_overrun_i(clr), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a)
  );

  cpu_result_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .flags_i(flags), .capture_i(cap_b),
    .clr_overrun_i(clr), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b)
  );

  // Scoreboard: one expected {tx,busy,done} per cycle while a frame is queued, idle line otherwise.
  always @(posedge clk) begin
    #1;
    checks++;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
    end else begin
      ea = 3'b100;
    end
    if ({tx_a, busy_a, done_a} !== ea) begin
      errors++;
      $display("FAIL line_a t=%0t {tx,busy,done} got=%b exp=%b", $time, {tx_a, busy_a, done_a}, ea);
    end
    checks++;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
    end else begin
      eb = 3'b100;
    end
    if ({tx_b, busy_b, done_b} !== eb) begin
      errors++;
      $display("FAIL line_b t=%0t {tx,busy,done} got=%b exp=%b", $time, {tx_b, busy_b, done_b}, eb);
    end
  end

  // seq holds the frame in send order, first bit in seq[nbits-1]; the done cycle is appended.
  task automatic push_bits(input logic [15:0] seq, input int nbits, input int cpb, input bit to_b);
    for (int i = nbits - 1; i >= 0; i--) begin
      for (int k = 0; k < cpb; k++) begin
        if (to_b) qb.push_back({seq[i], 2'b10});
        else      qa.push_back({seq[i], 2'b10});
      end
    end
    if (to_b) qb.push_back(3'b101);
    else      qa.push_back(3'b101);
  endtask

  task automatic push_model(input logic [7:0] d, input logic [3:0] f, input bit to_b);
    logic [15:0] seq;
    logic [11:0] pl;
    int          n;
    pl  = {f, d};
    seq = '0;
    n   = 1;
    for (int i = 0; i < 12; i++) begin
      seq = {seq[14:0], pl[i]};
      n++;
    end
    if (!to_b) begin
      seq = {seq[14:0], ^pl};
      n++;
    end
    seq = {seq[14:0], 1'b1};
    n++;
    push_bits(seq, n, to_b ? 1 : 4, to_b);
  endtask

  task automatic wait_done(input bit on_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((on_b ? done_b : done_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({tx_a, busy_a, done_a, ovr_a} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_a got=%b exp=1000", {tx_a, busy_a, done_a, ovr_a});
    end
    checks++;
    if ({tx_b, busy_b, done_b, ovr_b} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_b got=%b exp=1000", {tx_b, busy_b, done_b, ovr_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    bit ok;
    data = 8'hA5; flags = 4'b0010; cap_a = 1'b1;
    push_bits({1'b0, 15'b0_10100101_0100_1_1}, 15, 4, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_done got=timeout exp=done_pulse"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    data = 8'h00; flags = 4'b0000; cap_a = 1'b1;
    push_bits({1'b0, 15'b0_00000000_0000_0_1}, 15, 4, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first got=timeout exp=done_pulse"); end
    data = 8'hFF; flags = 4'b1111; cap_a = 1'b1;
    push_bits({1'b0, 15'b0_11111111_1111_0_1}, 15, 4, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    checks++;
    if ({tx_a, busy_a} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_start got={tx,busy}=%b exp=01", {tx_a, busy_a});
    end
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second got=timeout exp=done_pulse"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    bit ok;
    data = 8'h3C; flags = 4'b1100; cap_a = 1'b1;
    push_model(8'h3C, 4'b1100, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_pre got=%b exp=0", ovr_a); end
    data = 8'hFF; flags = 4'b1111; cap_a = 1'b1;
    @(negedge clk);
    cap_a = 1'b0;
    checks++;
    if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", ovr_a); end
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovr_frame got=timeout exp=done_pulse"); end
    checks++;
    if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", ovr_a); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", ovr_a); end
    data = 8'h81; flags = 4'b0001; cap_a = 1'b1;
    push_model(8'h81, 4'b0001, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    repeat (8) @(negedge clk);
    cap_a = 1'b1; clr = 1'b1;
    @(negedge clk);
    cap_a = 1'b0; clr = 1'b0;
    checks++;
    if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got=%b exp=1", ovr_a); end
    wait_done(1'b0, ok);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear2 got=%b exp=0", ovr_a); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    data = 8'hC3; flags = 4'b0110; cap_a = 1'b1;
    push_model(8'hC3, 4'b0110, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    rst_n = 1'b0;
    qa.delete();
    #1;
    checks++;
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid got={tx,busy,done}=%b exp=100", {tx_a, busy_a, done_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data = 8'h96; flags = 4'b1011; cap_a = 1'b1;
    push_model(8'h96, 4'b1011, 1'b0);
    @(negedge clk);
    cap_a = 1'b0;
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_resume got=timeout exp=done_pulse"); end
  endtask

  task automatic test_fast();
    bit         ok;
    logic [7:0] d;
    logic [3:0] f;
    data = 8'h3C; flags = 4'b0101; cap_b = 1'b1;
    push_bits({2'b00, 14'b0_00111100_1010_1}, 14, 1, 1'b1);
    @(negedge clk);
    cap_b = 1'b0;
    wait_done(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fast_done got=timeout exp=done_pulse"); end
    d = 8'($urandom); f = 4'($urandom);
    data = d; flags = f; cap_b = 1'b1;
    push_model(d, f, 1'b1);
    @(negedge clk);
    cap_b = 1'b0;
    wait_done(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fast_b2b got=timeout exp=done_pulse"); end
  endtask

  task automatic test_data_change();
    bit ok;
    data = 8'h5A; flags = 4'b1001; cap_a = 1'b1;
    push_model(8'h5A, 4'b1001, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cap_a = 1'b0;
      data  = 8'($urandom);
      flags = 4'($urandom);
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL change_a got=timeout exp=done_pulse"); end
    data = 8'hE7; flags = 4'b0011; cap_b = 1'b1;
    push_model(8'hE7, 4'b0011, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cap_b = 1'b0;
      data  = 8'($urandom);
      flags = 4'($urandom);
      if (done_b === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL change_b got=timeout exp=done_pulse"); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_fast();
    test_data_change();
    repeat (4) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d/%0d exp=0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
